// File: rtl/fxp_pkg.sv
// Fixed-point helpers for fxp_complex_multiplier: the SHIFT derivation, the
// saturation bounds and the shared round/saturate kernel.
package fxp_pkg;

  localparam int WIDE_W = 64;

  typedef logic signed [WIDE_W-1:0] wide_t;

  typedef struct packed {
    logic  sat;
    wide_t value;
  } rs_result_t;

  function automatic int shiftOf(input int fracA, input int fracB, input int fracP);
    return fracA + fracB - fracP;
  endfunction

  function automatic wide_t satMax(input int width);
    return (wide_t'(1) <<< (width - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t satMin(input int width);
    return -(wide_t'(1) <<< (width - 1));
  endfunction

  // Optional half-LSB bias goes in before the floor shift, and clamping comes last.
  function automatic rs_result_t roundSat(input wide_t x, input int shift,
                                          input int width, input logic roundEn);
    rs_result_t r;
    wide_t      t;
    t = x;
    if (roundEn && shift > 0) t = t + (wide_t'(1) <<< (shift - 1));
    t = t >>> shift;
    r.sat   = 1'b0;
    r.value = t;
    if (t > satMax(width)) begin
      r.sat   = 1'b1;
      r.value = satMax(width);
    end else if (t < satMin(width)) begin
      r.sat   = 1'b1;
      r.value = satMin(width);
    end
    return r;
  endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// Scales one wide complex-product component down to the output Q-format.
// Define FXP_CMUL_ROUND_EN for round-half-up; otherwise the shift truncates (floor).
module fxp_round_sat
  import fxp_pkg::*;
#(
  parameter int IN_W  = 33,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15
) (
  input  logic [IN_W-1:0]  val_i,
  output logic [OUT_W-1:0] val_o,
  output logic             sat_o
);

`ifdef FXP_CMUL_ROUND_EN
  localparam logic ROUND_EN = 1'b1;
`else
  localparam logic ROUND_EN = 1'b0;
`endif

  rs_result_t res;
  logic       unusedBits;

  always_comb begin
    res = roundSat(wide_t'($signed(val_i)), SHIFT, OUT_W, ROUND_EN);
  end

  assign val_o      = res.value[OUT_W-1:0];
  assign sat_o      = res.sat;
  assign unusedBits = ^res.value[WIDE_W-1:OUT_W];

endmodule

// File: rtl/fxp_complex_multiplier.sv
// Three-stage streaming complex multiplier P = A*B or A*conj(B) with saturation.
// Build with FXP_CMUL_ROUND_EN for round-half-up; the default build truncates.
module fxp_complex_multiplier
  import fxp_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_A = 15,
  parameter int FRAC_B = 15,
  parameter int FRAC_P = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a_re,
  input  logic [DATA_W-1:0] a_im,
  input  logic [DATA_W-1:0] b_re,
  input  logic [DATA_W-1:0] b_im,
  input  logic              conj_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] p_re,
  output logic [DATA_W-1:0] p_im,
  output logic              p_sat,
  output logic              sat_sticky,
  input  logic              clear_sat
);

  localparam int SHIFT  = shiftOf(FRAC_A, FRAC_B, FRAC_P);
  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = 2 * DATA_W + 1;

  if (SHIFT < 0 || SHIFT > 2 * DATA_W - 2) begin : gBadShift
    $error("fxp_complex_multiplier: SHIFT must lie in 0..2*DATA_W-2");
  end
  if (DATA_W < 2 || DATA_W > 31) begin : gBadWidth
    $error("fxp_complex_multiplier: DATA_W must lie in 2..31");
  end

  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [SUM_W-1:0]  sum_t;

  logic              ce;
  logic              v1_q, v2_q, v3_q;
  logic [DATA_W-1:0] aRe_q, aIm_q, bRe_q, bIm_q;
  logic              conj_q;
  prod_t             rr_d, ii_d, ri_d, ir_d;
  prod_t             rr_q, ii_q, ri_q, ir_q;
  sum_t              sumRe, sumIm;
  logic [DATA_W-1:0] rndRe, rndIm;
  logic              satRe, satIm;
  logic [DATA_W-1:0] pRe_q, pIm_q;
  logic              pSat_q;
  logic              sticky_q, sticky_d;

  // A held output beat freezes every stage at once.
  assign ce       = !(v3_q && !out_ready);
  assign in_ready = ce;

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else if (ce) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (ce && in_valid) begin
      aRe_q  <= a_re;
      aIm_q  <= a_im;
      bRe_q  <= b_re;
      bIm_q  <= b_im;
      conj_q <= conj_b;
    end
  end

  // Conjugation flips the sign of the bi products, never of an operand, so -2^(DATA_W-1) is safe.
  always_comb begin
    rr_d = prod_t'($signed(aRe_q)) * prod_t'($signed(bRe_q));
    ir_d = prod_t'($signed(aIm_q)) * prod_t'($signed(bRe_q));
    ii_d = prod_t'($signed(aIm_q)) * prod_t'($signed(bIm_q));
    ri_d = prod_t'($signed(aRe_q)) * prod_t'($signed(bIm_q));
    if (conj_q) begin
      ii_d = -ii_d;
      ri_d = -ri_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ce && v1_q) begin
      rr_q <= rr_d;
      ii_q <= ii_d;
      ri_q <= ri_d;
      ir_q <= ir_d;
    end
  end

  assign sumRe = sum_t'(rr_q) - sum_t'(ii_q);
  assign sumIm = sum_t'(ir_q) + sum_t'(ri_q);

  fxp_round_sat #(.IN_W(SUM_W), .OUT_W(DATA_W), .SHIFT(SHIFT)) uRoundRe (
    .val_i(sumRe),
    .val_o(rndRe),
    .sat_o(satRe)
  );

  fxp_round_sat #(.IN_W(SUM_W), .OUT_W(DATA_W), .SHIFT(SHIFT)) uRoundIm (
    .val_i(sumIm),
    .val_o(rndIm),
    .sat_o(satIm)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      v3_q   <= 1'b0;
      pRe_q  <= '0;
      pIm_q  <= '0;
      pSat_q <= 1'b0;
    end else if (ce) begin
      v3_q <= v2_q;
      if (v2_q) begin
        pRe_q  <= rndRe;
        pIm_q  <= rndIm;
        pSat_q <= satRe | satIm;
      end
    end
  end

  // A saturated beat leaving the block beats a simultaneous clear.
  always_comb begin
    sticky_d = sticky_q;
    if (clear_sat) sticky_d = 1'b0;
    if (v3_q && out_ready && pSat_q) sticky_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) sticky_q <= 1'b0;
    else       sticky_q <= sticky_d;
  end

  assign out_valid  = v3_q;
  assign p_re       = pRe_q;
  assign p_im       = pIm_q;
  assign p_sat      = pSat_q;
  assign sat_sticky = sticky_q;

endmodule

// File: tb/tb_fxp_complex_multiplier.sv
// Directed, table-driven bench for fxp_complex_multiplier in its default Q1.15 setup.
module tb_fxp_complex_multiplier;

  logic        clk;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic [15:0] aRe, aIm, bRe, bIm;
  logic        conjB;
  logic        outValid;
  logic        outReady;
  logic [15:0] pRe, pIm;
  logic        pSat;
  logic        satSticky;
  logic        clearSat;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] aRe, aIm, bRe, bIm;
    logic        conj;
    logic [15:0] expRe, expIm;
    logic        expSat;
  } vec_t;

  vec_t vecs[12];

  fxp_complex_multiplier dut (
    .clk(clk),
    .reset(reset),
    .in_valid(inValid),
    .in_ready(inReady),
    .a_re(aRe),
    .a_im(aIm),
    .b_re(bRe),
    .b_im(bIm),
    .conj_b(conjB),
    .out_valid(outValid),
    .out_ready(outReady),
    .p_re(pRe),
    .p_im(pIm),
    .p_sat(pSat),
    .sat_sticky(satSticky),
    .clear_sat(clearSat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives one beat and returns at the negedge where out_valid first shows (or the bound expires).
  task automatic applyStimulus(input vec_t v, output int lat);
    @(negedge clk);
    inValid = 1'b1;
    aRe = v.aRe; aIm = v.aIm; bRe = v.bRe; bIm = v.bIm; conjB = v.conj;
    #1;
    checkOutput("in_ready_idle", 32'(inReady), 32'd1);
    @(negedge clk);
    inValid = 1'b0;
    lat = 1;
    while (!outValid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic runBackpressure();
    int sent = 0;
    int got = 0;
    int extra = 0;
    logic [15:0] heldRe = '0;
    logic [15:0] heldIm = '0;
    logic holding = 1'b0;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      @(negedge clk);
      outReady = !(cyc >= 5 && cyc < 9);
      inValid  = (sent < 6);
      aRe = 16'((sent + 1) * 16'h0800); aIm = '0; bRe = 16'h4000; bIm = '0; conjB = 1'b0;
      #1;
      if (outValid && holding) begin
        checkOutput("bp_hold_re", 32'(pRe), 32'(heldRe));
        checkOutput("bp_hold_im", 32'(pIm), 32'(heldIm));
      end
      if (outValid && !outReady) begin
        checkOutput("bp_in_ready_low", 32'(inReady), 32'd0);
        holding = 1'b1;
        heldRe  = pRe;
        heldIm  = pIm;
      end else begin
        holding = 1'b0;
      end
      if (outValid && outReady) begin
        checkOutput($sformatf("bp_beat%0d_re", got), 32'(pRe), 32'((got + 1) * 16'h0400));
        checkOutput($sformatf("bp_beat%0d_im", got), 32'(pIm), 32'd0);
        got++;
      end
      if (inValid && inReady) sent++;
    end
    @(negedge clk);
    inValid  = 1'b0;
    outReady = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (outValid) extra++;
    end
    checkOutput("bp_sent", 32'(sent), 32'd6);
    checkOutput("bp_delivered", 32'(got), 32'd6);
    checkOutput("bp_no_dup", 32'(extra), 32'd0);
  endtask

  initial begin
    int lat;
    int stray;
    vec_t ov;

    vecs[0]  = '{16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b0, 16'h2000, 16'h0000, 1'b0};
    vecs[1]  = '{16'h4000, 16'h4000, 16'h4000, 16'hC000, 1'b0, 16'h4000, 16'h0000, 1'b0};
    vecs[2]  = '{16'h4000, 16'h4000, 16'h4000, 16'hC000, 1'b1, 16'h0000, 16'h4000, 1'b0};
    vecs[3]  = '{16'h8000, 16'h0000, 16'h8000, 16'h0000, 1'b0, 16'h7FFF, 16'h0000, 1'b1};
`ifdef FXP_CMUL_ROUND_EN
    vecs[4]  = '{16'h0001, 16'h0000, 16'h4000, 16'h0000, 1'b0, 16'h0001, 16'h0000, 1'b0};
    vecs[5]  = '{16'hFFFF, 16'h0000, 16'h4000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0};
`else
    vecs[4]  = '{16'h0001, 16'h0000, 16'h4000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[5]  = '{16'hFFFF, 16'h0000, 16'h4000, 16'h0000, 1'b0, 16'hFFFF, 16'h0000, 1'b0};
`endif
    vecs[6]  = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0, 16'h0000, 16'h7FFF, 1'b1};
    vecs[7]  = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b1, 16'h7FFF, 16'h0000, 1'b1};
    vecs[8]  = '{16'h8000, 16'h8000, 16'h7FFF, 16'h8000, 1'b0, 16'h8000, 16'h0001, 1'b1};
    vecs[9]  = '{16'h0000, 16'h0000, 16'h1234, 16'h5678, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[10] = '{16'h2000, 16'h1000, 16'h6000, 16'hE000, 1'b0, 16'h1C00, 16'h0400, 1'b0};
    vecs[11] = '{16'h8000, 16'h0000, 16'h7FFF, 16'h0000, 1'b0, 16'h8001, 16'h0000, 1'b0};

    reset = 1'b1; inValid = 1'b0; outReady = 1'b1; clearSat = 1'b0;
    aRe = '0; aIm = '0; bRe = '0; bIm = '0; conjB = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_out_valid", 32'(outValid), 32'd0);
    checkOutput("rst_p_re", 32'(pRe), 32'd0);
    checkOutput("rst_p_im", 32'(pIm), 32'd0);
    checkOutput("rst_p_sat", 32'(pSat), 32'd0);
    checkOutput("rst_sticky", 32'(satSticky), 32'd0);
    checkOutput("rst_in_ready", 32'(inReady), 32'd1);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i], lat);
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
      checkOutput($sformatf("vec%0d_re", i), 32'(pRe), 32'(vecs[i].expRe));
      checkOutput($sformatf("vec%0d_im", i), 32'(pIm), 32'(vecs[i].expIm));
      checkOutput($sformatf("vec%0d_sat", i), 32'(pSat), 32'(vecs[i].expSat));
      @(negedge clk);
      checkOutput($sformatf("vec%0d_sticky", i), 32'(satSticky), 32'(vecs[i].expSat));
      if (vecs[i].expSat) begin
        clearSat = 1'b1;
        @(negedge clk);
        clearSat = 1'b0;
        checkOutput($sformatf("vec%0d_sticky_clr", i), 32'(satSticky), 32'd0);
      end
    end

    // Clear asserted in the same cycle as a saturated transfer: the set must win.
    ov = vecs[3];
    applyStimulus(ov, lat);
    checkOutput("setwins_sat", 32'(pSat), 32'd1);
    clearSat = 1'b1;
    @(negedge clk);
    checkOutput("setwins_sticky", 32'(satSticky), 32'd1);
    @(negedge clk);
    clearSat = 1'b0;
    checkOutput("setwins_cleared", 32'(satSticky), 32'd0);

    // Leave sticky set, then reset with three beats in flight.
    applyStimulus(ov, lat);
    @(negedge clk);
    checkOutput("pre_rst_sticky", 32'(satSticky), 32'd1);
    for (int k = 0; k < 3; k++) begin
      inValid = 1'b1;
      aRe = 16'h1000; aIm = '0; bRe = 16'h4000; bIm = '0; conjB = 1'b0;
      @(negedge clk);
    end
    inValid = 1'b0;
    checkOutput("pre_rst_in_flight", 32'(outValid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midrst_out_valid", 32'(outValid), 32'd0);
    checkOutput("midrst_sticky", 32'(satSticky), 32'd0);
    checkOutput("midrst_p_re", 32'(pRe), 32'd0);
    checkOutput("midrst_in_ready", 32'(inReady), 32'd1);
    stray = 0;
    repeat (10) begin
      @(negedge clk);
      if (outValid) stray++;
    end
    checkOutput("midrst_no_stale", 32'(stray), 32'd0);

    runBackpressure();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fxp_complex_multiplier.md
Name: fxp_complex_multiplier

Overview:
Pipelined, parametrised signed fixed-point complex multiplier computing P = A·B, or A·conj(B) when selected, for FFT butterfly twiddle and IFFT paths. Supports independent Q-formats per operand and product, with round-half-up or truncation, and saturation with a sticky flag. Uses a streaming valid/ready handshake and sits between the butterfly add/sub stage and the twiddle ROM.

Parameters:
DATA_W, 16, width of each real/imag component of A, B and P (two's complement).
FRAC_A, 15, fractional bits of A.
FRAC_B, 15, fractional bits of B.
FRAC_P, 15, fractional bits of P.
SHIFT is derived as FRAC_A+FRAC_B-FRAC_P and must lie in 0..2*DATA_W-2. Out-of-range values are rejected by an elaboration-time check.

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high
in_valid  input  1  operand pair present
in_ready  output  1  block accepts operands this cycle
a_re, a_im  input  DATA_W each  operand A, signed
b_re, b_im  input  DATA_W each  operand B, signed
conj_b  input  1  sampled with operands; 1 means use conj(B)
out_valid  output  1  product valid
out_ready  input  1  downstream accepts product
p_re, p_im  output  DATA_W each  product, signed
p_sat  output  1  this output beat was saturated (either component)
sat_sticky  output  1  set on any saturated beat, held until clear_sat
clear_sat  input  1  clears sat_sticky

Behaviour:
- Reset (synchronous, active-high) clears all stage valid bits, p_re, p_im, p_sat and sat_sticky to 0. In-flight data is discarded. in_ready reads 1 in the cycle after reset.
- Global advance: ce = !(out_valid && !out_ready). in_ready = ce (combinational). Accept occurs when in_valid && in_ready.
- Pipeline has 3 stages; each valid bit is held when ce=0.
  - S1 registers operands and conj_b.
  - S2 forms four DATA_W×DATA_W signed products at 2*DATA_W bits. When conj flag is set, bi is negated at product level, so -ai·bi and ar·bi flip sign. No operand negation is used, so -2^(DATA_W-1) is handled.
  - S3 computes re = ar·br − ai·bi' and im = ai·br + ar·bi' at 2*DATA_W+1 bits, then applies the shift, rounding and saturation, and registers the outputs.
- Latency: an accept in cycle N produces out_valid in cycle N+3 when no stall occurs. Throughput is 1 result/cycle.
- Shift is arithmetic right by SHIFT (floor).
- Saturation: result is clamped to [−2^(DATA_W−1), 2^(DATA_W−1)−1]. p_sat = 1 if either component is clamped.
- Outputs hold stable while out_valid && !out_ready.
- sat_sticky: set when a beat with p_sat=1 transfers (out_valid && out_ready). clear_sat clears it. If clear and set occur in the same cycle, set wins.
- Zero operands need no special case; the arithmetic yields 0 exactly.

Optional Feature:
FXP_CMUL_ROUND_EN
- Defined: add 2^(SHIFT−1) before the shift (round half toward +inf), applied before saturation. With SHIFT=0, no rounding is applied.
- Undefined: truncation (floor). The latency is identical in both builds.

Decomposition:
- fxp_pkg holds:
  - saturation bounds as functions of width;
  - the SHIFT derivation;
  - a shared round/saturate function signature.
- One sub-module, fxp_round_sat (width in 2*DATA_W+1, out DATA_W, SHIFT), is instantiated twice in S3, once per component.

Test Plan:
- Q1.15 real-only: A=(0x4000,0), B=(0x4000,0), conj_b=0 -> p=(0x2000,0x0000), p_sat=0, 3 cycles after accept.
- Complex: A=(0x4000,0x4000), B=(0x4000,0xC000) -> p=(0x4000,0x0000). Same inputs with conj_b=1 -> p=(0x0000,0x4000).
- Overflow: A=(0x8000,0), B=(0x8000,0) -> p_re=0x7FFF, p_sat=1, sat_sticky=1 after transfer. A following clear_sat pulse -> sat_sticky=0.
- Rounding: A=(0x0001,0), B=(0x4000,0) -> p_re=0x0001 with FXP_CMUL_ROUND_EN, 0x0000 without. A=(0xFFFF,0), B=(0x4000,0) -> 0x0000 with it, 0xFFFF without.
- Backpressure: stream 6 distinct operands back-to-back and hold out_ready=0 for 4 cycles mid-stream -> in_ready drops, outputs held stable, all 6 results delivered in order with no loss or duplication.
- Reset mid-stream: assert reset with 3 beats in flight -> out_valid=0 the next cycle, no stale beat emitted afterward, sat_sticky=0.
